dma_copy_engine: RTL and testbench

//  Bus initiator for the byte-wide RAM. Copies a block of LEN bytes from SRC_ADDR to DST_ADDR
//  by driving the RAM's address/data/read_signal/write_signal and consuming its dataout.

---
 rtl/dma_copy_engine.sv | 191 +++++++++++++++++++
 tb/tb_dma_copy_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_copy_engine.sv
//------------------------------------------------------------------------------
// Module  : dma_copy_engine
// Brief   : Byte-wide RAM block copier (read, capture, write per byte) with a
//           start/done handshake. Optional checksum output: DMA_CHECKSUM_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dma_copy_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              aborted,
`ifdef DMA_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_read_signal,
  output logic              mem_write_signal,
  input  logic [DATA_W-1:0] mem_dataout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] c_ONE = LEN_W'(1);

  state_t            r_state, w_state_n;
  logic [ADDR_W-1:0] r_src, w_src_n, r_dst, w_dst_n, r_addr, w_addr_n;
  logic [LEN_W-1:0]  r_len, w_len_n, r_idx, w_idx_n;
  logic [DATA_W-1:0] r_data, w_data_n;
  logic              r_busy, w_busy_n, r_done, w_done_n, r_aborted, w_aborted_n;
  logic              r_rd, w_rd_n, r_wr, w_wr_n;
  logic [LEN_W-1:0]  w_idx_inc;
`ifdef DMA_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum, w_csum_n;
`endif

  assign w_idx_inc = r_idx + c_ONE;

  // Every output register is loaded with the value belonging to the state being entered.
  always_comb begin
    w_state_n   = r_state;
    w_src_n     = r_src;
    w_dst_n     = r_dst;
    w_len_n     = r_len;
    w_idx_n     = r_idx;
    w_data_n    = r_data;
    w_addr_n    = r_addr;
    w_busy_n    = r_busy;
    w_aborted_n = r_aborted;
    w_done_n    = 1'b0;
    w_rd_n      = 1'b0;
    w_wr_n      = 1'b0;
`ifdef DMA_CHECKSUM_EN
    w_csum_n    = r_csum;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_src_n     = src_addr;
          w_dst_n     = dst_addr;
          w_len_n     = len;
          w_idx_n     = '0;
          w_aborted_n = 1'b0;
`ifdef DMA_CHECKSUM_EN
          w_csum_n    = '0;
`endif
          if (len == '0) begin
            w_state_n = S_FIN;
            w_done_n  = 1'b1;
            w_busy_n  = 1'b0;
          end else begin
            w_state_n = S_RD;
            w_busy_n  = 1'b1;
            w_rd_n    = 1'b1;
            w_addr_n  = src_addr;
          end
        end
      end
      S_RD: begin
        if (abort) begin
          w_state_n   = S_FIN;
          w_done_n    = 1'b1;
          w_busy_n    = 1'b0;
          w_aborted_n = 1'b1;
        end else begin
          w_state_n = S_CAP;
        end
      end
      S_CAP: begin
        if (abort) begin
          w_state_n   = S_FIN;
          w_done_n    = 1'b1;
          w_busy_n    = 1'b0;
          w_aborted_n = 1'b1;
        end else begin
          // r_data doubles as the captured byte for the write that follows.
          w_state_n = S_WR;
          w_wr_n    = 1'b1;
          w_addr_n  = r_dst + ADDR_W'(r_idx);
          w_data_n  = mem_dataout;
        end
      end
      S_WR: begin
        w_idx_n = w_idx_inc;
`ifdef DMA_CHECKSUM_EN
        w_csum_n = r_csum + r_data;
`endif
        if (abort || (w_idx_inc == r_len)) begin
          w_state_n   = S_FIN;
          w_done_n    = 1'b1;
          w_busy_n    = 1'b0;
          w_aborted_n = abort;
        end else begin
          w_state_n = S_RD;
          w_rd_n    = 1'b1;
          w_addr_n  = r_src + ADDR_W'(w_idx_inc);
        end
      end
      S_FIN:   w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_data    <= '0;
      r_addr    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
`ifdef DMA_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_state   <= w_state_n;
      r_src     <= w_src_n;
      r_dst     <= w_dst_n;
      r_len     <= w_len_n;
      r_idx     <= w_idx_n;
      r_data    <= w_data_n;
      r_addr    <= w_addr_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_aborted <= w_aborted_n;
      r_rd      <= w_rd_n;
      r_wr      <= w_wr_n;
`ifdef DMA_CHECKSUM_EN
      r_csum    <= w_csum_n;
`endif
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign aborted          = r_aborted;
  assign mem_address      = r_addr;
  assign mem_data         = r_data;
  assign mem_read_signal  = r_rd;
  assign mem_write_signal = r_wr;
`ifdef DMA_CHECKSUM_EN
  assign checksum         = r_csum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine: behavioural RAM plus a forward-copy
// reference image; directed cases followed by randomized transfers.
`default_nettype none

module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [15:0] src_addr = '0, dst_addr = '0, len = '0;
  logic        busy, done, aborted;
  logic [15:0] mem_address;
  logic [7:0]  mem_data, mem_dataout;
  logic        mem_read_signal, mem_write_signal;
`ifdef DMA_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem  [0:65535];
  logic [7:0]  refm [0:65535];
  logic        p_en = 1'b0, fill_go = 1'b0;
  logic [15:0] p_addr = '0;
  logic [7:0]  p_data = '0, seed = '0;

  always #5 clk = ~clk;

  dma_copy_engine dut (
    .clk(clk), .RST(RST), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .aborted(aborted),
`ifdef DMA_CHECKSUM_EN
    .checksum(checksum),
`endif
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_read_signal(mem_read_signal), .mem_write_signal(mem_write_signal),
    .mem_dataout(mem_dataout)
  );

  function automatic logic [7:0] fillv(input int a, input logic [7:0] s);
    logic [15:0] aa;
    aa = 16'(a);
    return 8'(aa[7:0] * 8'd37) ^ aa[15:8] ^ s;
  endfunction

  // RAM: read data the cycle after the strobe, writes on negedge of the strobe cycle.
  always @(posedge clk) if (mem_read_signal) mem_dataout <= mem[mem_address];
  always @(negedge clk) begin
    if (fill_go) for (int a = 0; a < 65536; a++) mem[a] = fillv(a, seed);
    if (p_en) mem[p_addr] = p_data;
    if (mem_write_signal) mem[mem_address] = mem_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] v);
    p_addr = a; p_data = v; p_en = 1'b1;
    refm[a] = v;
    @(negedge clk); #1;
    p_en = 1'b0;
  endtask

  task automatic do_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                         input int ab_k, input int st_k, input int rs_k);
    int ll, k, nw, nr, exp_lat, b, ph, rd_bad, wr_bad, ram_bad, ov, busy_bad, late_done;
    logic [15:0] rq[$];
    logic [15:0] wq[$];
    logic [15:0] ai;
    logic [7:0]  sum;
    bit ab_ok, killed, tmo;
    ll = int'(l);
    ab_ok = (ab_k >= 1) && (ab_k <= 3 * ll);
    killed = 0; tmo = 0; ov = 0; busy_bad = 0; late_done = 0;
    exp_lat = 3 * ll + 1;
    if (rs_k > 0) begin
      nw = (rs_k / 3 < ll) ? rs_k / 3 : ll;
      nr = ((rs_k + 2) / 3 < ll) ? (rs_k + 2) / 3 : ll;
    end else if (ab_ok) begin
      b = (ab_k - 1) / 3; ph = (ab_k - 1) % 3;
      nw = (ph == 2) ? b + 1 : b;
      nr = b + 1;
      exp_lat = ab_k + 1;
    end else begin
      nw = ll; nr = ll;
    end
    // Reference: strict forward byte-by-byte copy with 16-bit address wrap.
    sum = '0;
    for (int i = 0; i < nw; i++) begin
      ai = 16'(i);
      refm[d + ai] = refm[s + ai];
      sum = sum + refm[s + ai];
    end

    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = l;
    k = 0;
    while (1) begin
      @(negedge clk);
      k++;
      if (mem_read_signal)  rq.push_back(mem_address);
      if (mem_write_signal) wq.push_back(mem_address);
      if (mem_read_signal && mem_write_signal) ov++;
      if (done) break;
      if (!busy) busy_bad++;
      if (k == rs_k) begin
        killed = 1;
        #2 RST = 1'b1;
        #1 chk("rst_async_outs", {busy, done, aborted, mem_read_signal, mem_write_signal,
                                   mem_address, mem_data}, 64'd0);
        @(negedge clk);
        RST = 1'b0;
        break;
      end
      if (k > 3 * ll + 5) begin
        tmo = 1;
        chk("done_timeout", 64'(k), 64'(exp_lat));
        break;
      end
      start = (k == st_k);
      if (start) begin src_addr = ~s; dst_addr = ~d; len = 16'd3; end
      abort = (k == ab_k);
    end
    start = 1'b0; abort = 1'b0;

    if (killed) begin
      for (int c = 0; c < 3 * ll + 3; c++) begin
        @(negedge clk);
        if (done || busy) late_done++;
      end
      chk("no_done_after_rst", 64'(late_done), 64'd0);
`ifdef DMA_CHECKSUM_EN
      chk("checksum_after_rst", 64'(checksum), 64'd0);
`endif
    end else if (!tmo) begin
      chk("latency", 64'(k), 64'(exp_lat));
      chk("aborted", 64'(aborted), 64'(ab_ok));
      chk("busy_at_done", 64'(busy), 64'd0);
`ifdef DMA_CHECKSUM_EN
      chk("checksum", 64'(checksum), 64'(sum));
`endif
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
    end

    rd_bad = (rq.size() != nr) ? 1 : 0;
    for (int i = 0; i < rq.size() && i < nr; i++) if (rq[i] !== s + 16'(i)) rd_bad++;
    wr_bad = (wq.size() != nw) ? 1 : 0;
    for (int i = 0; i < wq.size() && i < nw; i++) if (wq[i] !== d + 16'(i)) wr_bad++;
    chk("read_addr_seq", 64'(rd_bad), 64'd0);
    chk("write_addr_seq", 64'(wr_bad), 64'd0);
    chk("rd_wr_overlap", 64'(ov), 64'd0);
    chk("busy_during_xfer", 64'(busy_bad), 64'd0);
    ram_bad = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] !== refm[a]) ram_bad++;
    chk("ram_image", 64'(ram_bad), 64'd0);
  endtask

  initial begin
    logic [7:0] exp4 [4];
    logic [7:0] old_fffe;
    logic [15:0] rs, rd, rl;
    int rab, rst_k;

    seed = 8'($urandom);
    for (int a = 0; a < 65536; a++) refm[a] = fillv(a, seed);
    @(negedge clk);
    fill_go = 1'b1;
    @(negedge clk); #1;
    fill_go = 1'b0;
    chk("reset_outs", {busy, done, aborted, mem_read_signal, mem_write_signal,
                       mem_address, mem_data}, 64'd0);
`ifdef DMA_CHECKSUM_EN
    chk("reset_checksum", 64'(checksum), 64'd0);
`endif
    @(negedge clk);
    RST = 1'b0;

    // Basic four-byte copy.
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;
    for (int i = 0; i < 4; i++) poke(16'h0010 + 16'(i), exp4[i]);
    do_xfer(16'h0010, 16'h0100, 16'd4, -1, -1, -1);
    for (int i = 0; i < 4; i++) chk("copy4_byte", 64'(mem[16'h0100 + 16'(i)]), 64'(exp4[i]));
`ifdef DMA_CHECKSUM_EN
    chk("copy4_checksum", 64'(checksum), 64'hAA);
`endif

    // Zero length: no RAM access, done one cycle after accept.
    do_xfer(16'h0050, 16'h0060, 16'd0, -1, -1, -1);

    // Source and destination wrap; byte 2 reads back the freshly written byte 0.
    old_fffe = refm[16'hFFFE];
    do_xfer(16'hFFFE, 16'h0000, 16'd4, -1, -1, -1);
    chk("wrap_readback", 64'(mem[16'h0002]), 64'(old_fffe));

    // Overlap dst==src+1 replicates the first byte.
    poke(16'h0020, 8'h5A);
    do_xfer(16'h0020, 16'h0021, 16'd3, -1, -1, -1);
    for (int i = 1; i <= 3; i++) chk("overlap_fill", 64'(mem[16'h0020 + 16'(i)]), 64'h5A);

    // Abort in CAP of byte 2 with a stray start while busy.
    do_xfer(16'h0200, 16'h0300, 16'd8, 8, 3, -1);
    // Abort in RD of byte 1, and in WR of byte 1.
    do_xfer(16'h0400, 16'h0480, 16'd5, 4, -1, -1);
    do_xfer(16'h0400, 16'h04C0, 16'd5, 6, -1, -1);
    // Abort in the last WR still reports aborted.
    do_xfer(16'h0600, 16'h0700, 16'd2, 6, -1, -1);

    // Reset during WR of byte 1, then a normal transfer.
    do_xfer(16'h0800, 16'h0900, 16'd4, -1, -1, 6);
    do_xfer(16'h0800, 16'h0A00, 16'd4, -1, -1, -1);

    for (int t = 0; t < 12; t++) begin
      rs = 16'($urandom);
      rd = rs + 16'($urandom_range(0, 20)) - 16'd10;
      rl = 16'($urandom_range(0, 16));
      rab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3 * int'(rl) + 1)) : -1;
      rst_k = ($urandom_range(0, 7) == 0 && rl > 16'd1) ? int'($urandom_range(1, 3 * int'(rl))) : -1;
      if (rst_k > 0) rab = -1;
      do_xfer(rs, rd, rl, rab, int'($urandom_range(1, 6)), rst_k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
